rd_pipe_decode: RTL and testbench

Parametrised, registered successor to the combinational decode stage of the minicpu MIPS pipeline. It sits between fetch (stage 2 instruction) and execute. It produces RS/RT/RD specifiers, an XLEN-wide immediate, and syscall/illegal flags, with one cycle of latency behind a valid/ready handshake. It adds load-use hazard stalling, a counted syscall stall FSM, and registered security labels.

---
 rtl/rd_pipe_decode_pkg.sv | 106 ++++++++++
 rtl/rd_pipe_decode_if.sv | 36 +++
 rtl/rd_pipe_decode_comb.sv | 101 ++++++++++
 rtl/rd_pipe_decode.sv | 127 ++++++++++++
 tb/tb_rd_pipe_decode.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd_pipe_decode_pkg.sv
// Shared MIPS encodings, field slices and FSM state for the registered decode stage.
package rd_pipe_decode_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP1    = 6'h11;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_LWC1    = 6'h31;
    localparam logic [5:0] OP_SWC1    = 6'h39;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;
    localparam logic [4:0] R0      = 5'd0;
    localparam logic [4:0] R31     = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SYSWAIT,
        ST_HALT
    } dec_state_e;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_RT,
        WB_RD,
        WB_R31
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_SEXT,
        IMM_ZEXT,
        IMM_LUI,
        IMM_JIDX
    } imm_kind_e;

    function automatic logic [5:0] f_op(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[15:11];
    endfunction

    function automatic logic [5:0] f_fn(input logic [31:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/rd_pipe_decode_if.sv
// Fetch/execute-facing bundle of the decode stage; slave side is the decoder.
interface rd_pipe_decode_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5,
    parameter int LABEL_W  = 1
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         I1;
    logic [LABEL_W-1:0]  in_label;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_is_load;
    logic                out_valid;
    logic                out_ready;
    logic [REG_BITS-1:0] RSaddr;
    logic [REG_BITS-1:0] RTaddr;
    logic [REG_BITS-1:0] RDaddr;
    logic [XLEN-1:0]     Imm;
    logic                instIsSyscall;
    logic                illegal;
    logic [LABEL_W-1:0]  ReadLabel;
    logic [LABEL_W-1:0]  WriteLabel;
    logic                stall;

    modport master (
        output in_valid, I1, in_label, ex_rd, ex_is_load, out_ready,
        input  in_ready, out_valid, RSaddr, RTaddr, RDaddr, Imm,
               instIsSyscall, illegal, ReadLabel, WriteLabel, stall
    );

    modport slave (
        input  in_valid, I1, in_label, ex_rd, ex_is_load, out_ready,
        output in_ready, out_valid, RSaddr, RTaddr, RDaddr, Imm,
               instIsSyscall, illegal, ReadLabel, WriteLabel, stall
    );
endinterface

// File: rtl/rd_pipe_decode_comb.sv
// Pure combinational MIPS field decode: specifiers, extended immediate, syscall/illegal.
module rd_decode_comb
    import rd_pipe_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic [31:0]         instr_i,
    output logic [REG_BITS-1:0] rs_o,
    output logic [REG_BITS-1:0] rt_o,
    output logic [REG_BITS-1:0] rd_o,
    output logic [XLEN-1:0]     imm_o,
    output logic                syscall_o,
    output logic                illegal_o
);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt_f;
    wb_sel_e    wb;
    imm_kind_e  ik;
    logic       ill;
    logic       sys;

    assign op   = f_op(instr_i);
    assign fn   = f_fn(instr_i);
    assign rt_f = f_rt(instr_i);

    assign rs_o = REG_BITS'(f_rs(instr_i));
    assign rt_o = REG_BITS'(rt_f);

    always_comb begin
        wb  = WB_NONE;
        ik  = IMM_NONE;
        ill = 1'b0;
        sys = 1'b0;
        case (op)
            OP_SPECIAL: case (fn)
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                FN_JALR, FN_MFHI, FN_MFLO,
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: wb = WB_RD;
                FN_JR, FN_MTHI, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: wb = WB_NONE;
                FN_SYSCALL: sys = 1'b1;
                default: ill = 1'b1;
            endcase
            OP_REGIMM: begin
                if (rt_f == RT_BLTZ || rt_f == RT_BGEZ) ik = IMM_SEXT;
                else                                    ill = 1'b1;
            end
            OP_J:   ik = IMM_JIDX;
            OP_JAL: begin
                ik = IMM_JIDX;
                wb = WB_R31;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_SB, OP_SH, OP_SW: ik = IMM_SEXT;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ik = IMM_SEXT;
                wb = WB_RT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ik = IMM_ZEXT;
                wb = WB_RT;
            end
            OP_LUI: begin
                ik = IMM_LUI;
                wb = WB_RT;
            end
            // FPU ops are accepted but flow through as NOPs
            OP_COP1, OP_LWC1, OP_SWC1: ik = IMM_NONE;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            wb  = WB_NONE;
            ik  = IMM_NONE;
            sys = 1'b0;
        end
    end

    always_comb begin
        case (wb)
            WB_RT:   rd_o = REG_BITS'(rt_f);
            WB_RD:   rd_o = REG_BITS'(f_rd(instr_i));
            WB_R31:  rd_o = REG_BITS'(R31);
            default: rd_o = REG_BITS'(R0);
        endcase
        case (ik)
            IMM_SEXT: imm_o = XLEN'($signed(instr_i[15:0]));
            IMM_ZEXT: imm_o = XLEN'(instr_i[15:0]);
            IMM_LUI:  imm_o = XLEN'($signed({instr_i[15:0], 16'h0000}));
            IMM_JIDX: imm_o = XLEN'(instr_i[25:0]);
            default:  imm_o = '0;
        endcase
    end

    assign syscall_o = sys;
    assign illegal_o = ill;

endmodule

// File: rtl/rd_pipe_decode.sv
// Registered decode stage: valid/ready handshake, load-use hazard, syscall stall FSM.
// Optional ILLEGAL_TRAP_EN: accepting an illegal opcode parks the stage in HALT until MRST.
module rd_pipe_decode
    import rd_pipe_decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_BITS      = 5,
    parameter int SYSCALL_STALL = 2,
    parameter int LABEL_W       = 1
) (
    input logic              CLK,
    input logic              MRST,
    rd_pipe_decode_if.slave  bus
);
    logic [REG_BITS-1:0] dec_rs;
    logic [REG_BITS-1:0] dec_rt;
    logic [REG_BITS-1:0] dec_rd;
    logic [XLEN-1:0]     dec_imm;
    logic                dec_sys;
    logic                dec_ill;

    dec_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    logic                out_valid_q;
    logic [REG_BITS-1:0] rs_q, rt_q, rd_q;
    logic [XLEN-1:0]     imm_q;
    logic                sys_q, ill_q;
    logic [LABEL_W-1:0]  rlabel_q, wlabel_q;

    logic                hazard;
    logic                in_ready;
    logic                accept;

    rd_decode_comb #(
        .XLEN     (XLEN),
        .REG_BITS (REG_BITS)
    ) u_dec (
        .instr_i   (bus.I1),
        .rs_o      (dec_rs),
        .rt_o      (dec_rt),
        .rd_o      (dec_rd),
        .imm_o     (dec_imm),
        .syscall_o (dec_sys),
        .illegal_o (dec_ill)
    );

    // Raw rs/rt slices are compared regardless of opcode, matching the fetch-side view.
    assign hazard   = bus.ex_is_load && (bus.ex_rd != '0) &&
                      ((bus.ex_rd == dec_rs) || (bus.ex_rd == dec_rt));
    assign in_ready = (state_q == ST_RUN) && !hazard && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && dec_sys) begin
                    state_d = ST_SYSWAIT;
                    cnt_d   = 4'(SYSCALL_STALL);
                end
`ifdef ILLEGAL_TRAP_EN
                if (accept && dec_ill) state_d = ST_HALT;
`endif
            end
            ST_SYSWAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (MRST) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            sys_q       <= 1'b0;
            ill_q       <= 1'b0;
            rlabel_q    <= '0;
            wlabel_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                rs_q        <= dec_rs;
                rt_q        <= dec_rt;
                rd_q        <= dec_rd;
                imm_q       <= dec_imm;
                sys_q       <= dec_sys;
                ill_q       <= dec_ill;
                rlabel_q    <= bus.in_label;
                wlabel_q    <= bus.in_label;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.RSaddr        = rs_q;
    assign bus.RTaddr        = rt_q;
    assign bus.RDaddr        = rd_q;
    assign bus.Imm           = imm_q;
    assign bus.instIsSyscall = sys_q;
    assign bus.illegal       = ill_q;
    assign bus.ReadLabel     = rlabel_q;
    assign bus.WriteLabel    = wlabel_q;
    assign bus.stall         = (hazard && bus.in_valid) || (state_q != ST_RUN);

endmodule

// File: tb/tb_rd_pipe_decode.sv
// Directed table, handshake corner sequences and randomized run against a spec-level model.
module tb_rd_pipe_decode;
    localparam int XLEN          = 32;
    localparam int REG_BITS      = 5;
    localparam int SYSCALL_STALL = 2;
    localparam int LABEL_W       = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rd_pipe_decode_if #(.XLEN(XLEN), .REG_BITS(REG_BITS), .LABEL_W(LABEL_W)) dif ();

    rd_pipe_decode #(
        .XLEN          (XLEN),
        .REG_BITS      (REG_BITS),
        .SYSCALL_STALL (SYSCALL_STALL),
        .LABEL_W       (LABEL_W)
    ) dut (
        .CLK  (clk),
        .MRST (rst),
        .bus  (dif)
    );

    typedef struct {
        logic [31:0]     w;
        logic            lbl;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            sys;
        logic            ill;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [5:0] legal_ops [0:26] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                     6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                     6'h11, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                                     6'h2B, 6'h31, 6'h39};
    logic [5:0] legal_fns [0:25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                     6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                     6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h2A, 6'h2B};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] w, input logic lbl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [XLEN-1:0] imm, input logic sys, input logic ill);
        vec_t v;
        v.w = w; v.lbl = lbl; v.rs = rs; v.rt = rt; v.rd = rd;
        v.imm = imm; v.sys = sys; v.ill = ill;
        return v;
    endfunction

    // Expected decode computed straight from the MIPS field rules.
    function automatic vec_t ref_dec(input logic [31:0] w);
        vec_t d;
        logic [5:0] op, fn;
        logic [XLEN-1:0] se, ze, lu, jt;
        op = w[31:26];
        fn = w[5:0];
        se = XLEN'($signed(w[15:0]));
        ze = XLEN'(w[15:0]);
        lu = XLEN'($signed({w[15:0], 16'h0000}));
        jt = XLEN'(w[25:0]);
        d.w = w; d.lbl = 1'b0; d.rs = w[25:21]; d.rt = w[20:16]; d.rd = 5'd0;
        d.imm = '0; d.sys = 1'b0; d.ill = 1'b0;
        if (op == 6'h00) begin
            if (fn == 6'h0C) d.sys = 1'b1;
            else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                                [6'h20:6'h27], 6'h2A, 6'h2B}) d.rd = w[15:11];
            else if (!(fn inside {6'h08, 6'h11, 6'h13, [6'h18:6'h1B]})) d.ill = 1'b1;
        end else if (op == 6'h01) begin
            if (w[20:16] inside {5'd0, 5'd1}) d.imm = se;
            else d.ill = 1'b1;
        end else if (op inside {6'h02, 6'h03}) begin
            d.imm = jt;
            if (op == 6'h03) d.rd = 5'd31;
        end else if (op inside {[6'h04:6'h07], 6'h28, 6'h29, 6'h2B}) begin
            d.imm = se;
        end else if (op inside {[6'h08:6'h0B], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            d.imm = se; d.rd = w[20:16];
        end else if (op inside {[6'h0C:6'h0E]}) begin
            d.imm = ze; d.rd = w[20:16];
        end else if (op == 6'h0F) begin
            d.imm = lu; d.rd = w[20:16];
        end else if (!(op inside {6'h11, 6'h31, 6'h39})) begin
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int r;
        r = $urandom_range(0, 15);
        w = $urandom;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        if (r == 0) begin
            w[31:26] = 6'h00;
            w[5:0]   = 6'h0C;
`ifndef ILLEGAL_TRAP_EN
        end else if (r == 1) begin
            w[31:26] = (w[0]) ? 6'h3F : 6'h13;
`endif
        end else begin
            w[31:26] = legal_ops[$urandom_range(0, 26)];
            if (w[31:26] == 6'h00) w[5:0] = legal_fns[$urandom_range(0, 25)];
            if (w[31:26] == 6'h01) w[20:16] = 5'($urandom_range(0, 1));
        end
        return w;
    endfunction

    task automatic chk_out(input string t, input vec_t e, input logic lbl);
        chk({t, ".out_valid"}, 64'(dif.out_valid), 64'(1'b1));
        chk({t, ".RSaddr"},    64'(dif.RSaddr), 64'(e.rs));
        chk({t, ".RTaddr"},    64'(dif.RTaddr), 64'(e.rt));
        chk({t, ".RDaddr"},    64'(dif.RDaddr), 64'(e.rd));
        chk({t, ".Imm"},       64'(dif.Imm), 64'(e.imm));
        chk({t, ".syscall"},   64'(dif.instIsSyscall), 64'(e.sys));
        chk({t, ".illegal"},   64'(dif.illegal), 64'(e.ill));
        chk({t, ".rlabel"},    64'(dif.ReadLabel), 64'(lbl));
        chk({t, ".wlabel"},    64'(dif.WriteLabel), 64'(lbl));
    endtask

    task automatic chk_cleared(input string t);
        chk({t, ".out_valid"}, 64'(dif.out_valid), 64'(1'b0));
        chk({t, ".RSaddr"},    64'(dif.RSaddr), 64'd0);
        chk({t, ".RTaddr"},    64'(dif.RTaddr), 64'd0);
        chk({t, ".RDaddr"},    64'(dif.RDaddr), 64'd0);
        chk({t, ".Imm"},       64'(dif.Imm), 64'd0);
        chk({t, ".syscall"},   64'(dif.instIsSyscall), 64'd0);
        chk({t, ".illegal"},   64'(dif.illegal), 64'd0);
        chk({t, ".rlabel"},    64'(dif.ReadLabel), 64'd0);
        chk({t, ".wlabel"},    64'(dif.WriteLabel), 64'd0);
    endtask

    vec_t tbl [17];

    initial begin
        vec_t m_exp;
        logic m_ov, m_lbl;
        int   m_busy;

        tbl[0]  = mk(32'h2065FFFC, 1'b1, 5'd3,  5'd5,  5'd5,  32'hFFFFFFFC, 1'b0, 1'b0);
        tbl[1]  = mk(32'h00622020, 1'b0, 5'd3,  5'd2,  5'd4,  32'h00000000, 1'b0, 1'b0);
        tbl[2]  = mk(32'h3C011234, 1'b1, 5'd0,  5'd1,  5'd1,  32'h12340000, 1'b0, 1'b0);
        tbl[3]  = mk(32'h3C028000, 1'b0, 5'd0,  5'd2,  5'd2,  32'h80000000, 1'b0, 1'b0);
        tbl[4]  = mk(32'h34C7FFFF, 1'b1, 5'd6,  5'd7,  5'd7,  32'h0000FFFF, 1'b0, 1'b0);
        tbl[5]  = mk(32'h8FA8FFF8, 1'b0, 5'd29, 5'd8,  5'd8,  32'hFFFFFFF8, 1'b0, 1'b0);
        tbl[6]  = mk(32'hAFA80004, 1'b1, 5'd29, 5'd8,  5'd0,  32'h00000004, 1'b0, 1'b0);
        tbl[7]  = mk(32'h0C100000, 1'b0, 5'd0,  5'd16, 5'd31, 32'h00100000, 1'b0, 1'b0);
        tbl[8]  = mk(32'h0120F809, 1'b1, 5'd9,  5'd0,  5'd31, 32'h00000000, 1'b0, 1'b0);
        tbl[9]  = mk(32'h1022FFFF, 1'b0, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 1'b0, 1'b0);
        tbl[10] = mk(32'h00851818, 1'b1, 5'd4,  5'd5,  5'd0,  32'h00000000, 1'b0, 1'b0);
        tbl[11] = mk(32'h00031100, 1'b0, 5'd0,  5'd3,  5'd2,  32'h00000000, 1'b0, 1'b0);
        tbl[12] = mk(32'h44A21800, 1'b1, 5'd5,  5'd2,  5'd0,  32'h00000000, 1'b0, 1'b0);
        tbl[13] = mk(32'hC4000010, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0);
        tbl[14] = mk(32'h2C298000, 1'b1, 5'd1,  5'd9,  5'd9,  32'hFFFF8000, 1'b0, 1'b0);
        tbl[15] = mk(32'h30638001, 1'b0, 5'd3,  5'd3,  5'd3,  32'h00008001, 1'b0, 1'b0);
        tbl[16] = mk(32'h04810002, 1'b1, 5'd4,  5'd1,  5'd0,  32'h00000002, 1'b0, 1'b0);

        rst = 1'b1;
        dif.in_valid = 1'b0; dif.I1 = 32'h0; dif.in_label = '0;
        dif.ex_rd = '0; dif.ex_is_load = 1'b0; dif.out_ready = 1'b1;
        cyc(); cyc();
        #1;
        chk_cleared("reset");
        chk("reset.in_ready", 64'(dif.in_ready), 64'd1);
        chk("reset.stall",    64'(dif.stall), 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc();
            dif.I1 = tbl[i].w; dif.in_label = tbl[i].lbl; dif.in_valid = 1'b1;
            #1 chk($sformatf("tbl%0d.in_ready", i), 64'(dif.in_ready), 64'd1);
            cyc();
            dif.in_valid = 1'b0;
            #1 chk_out($sformatf("tbl%0d", i), tbl[i], tbl[i].lbl);
        end

        // load-use hazard on rs, then on rt, then released
        cyc();
        dif.I1 = 32'h00622020; dif.in_label = 1'b0; dif.in_valid = 1'b1;
        dif.ex_is_load = 1'b1; dif.ex_rd = 5'd3;
        #1 chk("haz.rs.in_ready", 64'(dif.in_ready), 64'd0);
        chk("haz.rs.stall", 64'(dif.stall), 64'd1);
        cyc();
        #1 chk("haz.drain", 64'(dif.out_valid), 64'd0);
        chk("haz.hold.in_ready", 64'(dif.in_ready), 64'd0);
        dif.ex_rd = 5'd2;
        #1 chk("haz.rt.in_ready", 64'(dif.in_ready), 64'd0);
        chk("haz.rt.stall", 64'(dif.stall), 64'd1);
        cyc();
        dif.ex_is_load = 1'b0;
        #1 chk("haz.rel.in_ready", 64'(dif.in_ready), 64'd1);
        chk("haz.rel.stall", 64'(dif.stall), 64'd0);
        cyc();
        dif.in_valid = 1'b0;
        #1 chk("haz.acc.out_valid", 64'(dif.out_valid), 64'd1);
        chk("haz.acc.RDaddr", 64'(dif.RDaddr), 64'd4);
        // load into r0 never stalls
        dif.I1 = 32'h3C011234; dif.ex_is_load = 1'b1; dif.ex_rd = 5'd0; dif.in_valid = 1'b1;
        #1 chk("haz.r0.in_ready", 64'(dif.in_ready), 64'd1);
        chk("haz.r0.stall", 64'(dif.stall), 64'd0);
        dif.in_valid = 1'b0; dif.ex_is_load = 1'b0;

        // syscall holds in_ready low for SYSCALL_STALL cycles
        cyc();
        dif.I1 = 32'h0000000C; dif.in_valid = 1'b1;
        #1 chk("sys.in_ready0", 64'(dif.in_ready), 64'd1);
        cyc();
        dif.I1 = 32'h2065FFFC;
        #1 chk("sys.out_valid", 64'(dif.out_valid), 64'd1);
        chk("sys.flag", 64'(dif.instIsSyscall), 64'd1);
        chk("sys.RDaddr", 64'(dif.RDaddr), 64'd0);
        chk("sys.c1.in_ready", 64'(dif.in_ready), 64'd0);
        chk("sys.c1.stall", 64'(dif.stall), 64'd1);
        cyc();
        #1 chk("sys.c2.in_ready", 64'(dif.in_ready), 64'd0);
        chk("sys.c2.stall", 64'(dif.stall), 64'd1);
        cyc();
        #1 chk("sys.c3.in_ready", 64'(dif.in_ready), 64'd1);
        chk("sys.c3.stall", 64'(dif.stall), 64'd0);
        cyc();
        dif.in_valid = 1'b0;
        #1 chk("sys.next.RTaddr", 64'(dif.RTaddr), 64'd5);
        chk("sys.next.Imm", 64'(dif.Imm), 64'hFFFFFFFC);

        // backpressure holds LUI result stable
        cyc();
        dif.I1 = 32'h3C011234; dif.in_valid = 1'b1;
        #1 chk("bp.in_ready0", 64'(dif.in_ready), 64'd1);
        cyc();
        dif.I1 = 32'h34C7FFFF; dif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp.hold%0d.Imm", k), 64'(dif.Imm), 64'h12340000);
            chk($sformatf("bp.hold%0d.valid", k), 64'(dif.out_valid), 64'd1);
            chk($sformatf("bp.hold%0d.in_ready", k), 64'(dif.in_ready), 64'd0);
            cyc();
        end
        dif.out_ready = 1'b1;
        #1 chk("bp.rel.in_ready", 64'(dif.in_ready), 64'd1);
        chk("bp.rel.Imm", 64'(dif.Imm), 64'h12340000);
        cyc();
        dif.in_valid = 1'b0;
        #1 chk("bp.swap.valid", 64'(dif.out_valid), 64'd1);
        chk("bp.swap.Imm", 64'(dif.Imm), 64'h0000FFFF);
        chk("bp.swap.RDaddr", 64'(dif.RDaddr), 64'd7);

        // illegal opcode 0x3F
        cyc();
        dif.I1 = 32'hFC000000; dif.in_valid = 1'b1;
        #1 chk("ill.in_ready0", 64'(dif.in_ready), 64'd1);
        cyc();
        dif.I1 = 32'h00622020;
        #1 chk("ill.flag", 64'(dif.illegal), 64'd1);
        chk("ill.RDaddr", 64'(dif.RDaddr), 64'd0);
        chk("ill.Imm", 64'(dif.Imm), 64'd0);
        chk("ill.syscall", 64'(dif.instIsSyscall), 64'd0);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("halt%0d.in_ready", k), 64'(dif.in_ready), 64'd0);
            chk($sformatf("halt%0d.stall", k), 64'(dif.stall), 64'd1);
            cyc();
        end
        dif.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 chk("halt.rst.in_ready", 64'(dif.in_ready), 64'd1);
        chk("halt.rst.out_valid", 64'(dif.out_valid), 64'd0);
`else
        chk("ill.in_ready1", 64'(dif.in_ready), 64'd1);
        cyc();
        dif.in_valid = 1'b0;
        #1 chk("ill.next.flag", 64'(dif.illegal), 64'd0);
        chk("ill.next.RDaddr", 64'(dif.RDaddr), 64'd4);
`endif

        // reset in SYSWAIT with a held beat
        cyc();
        dif.I1 = 32'h0000000C; dif.in_label = 1'b1; dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        #1 chk("rsw.in_ready0", 64'(dif.in_ready), 64'd1);
        cyc();
        dif.in_valid = 1'b0; dif.out_ready = 1'b0;
        #1 chk("rsw.out_valid", 64'(dif.out_valid), 64'd1);
        chk("rsw.stall", 64'(dif.stall), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 chk_cleared("rsw");
        chk("rsw.in_ready", 64'(dif.in_ready), 64'd1);
        chk("rsw.stall0", 64'(dif.stall), 64'd0);

        // randomized run against the cycle model
        m_ov = 1'b0; m_lbl = 1'b0; m_busy = 0; m_exp = ref_dec(32'h0);
        for (int n = 0; n < 400; n++) begin
            logic haz, exp_rdy, acc;
            cyc();
            dif.I1         = rnd_instr();
            dif.in_label   = LABEL_W'($urandom_range(0, 1));
            dif.in_valid   = ($urandom_range(0, 3) != 0);
            dif.out_ready  = ($urandom_range(0, 3) != 0);
            dif.ex_is_load = ($urandom_range(0, 2) == 0);
            dif.ex_rd      = REG_BITS'($urandom_range(0, 7));
            #1;
            haz = dif.ex_is_load && dif.ex_rd != 0 &&
                  (dif.ex_rd == dif.I1[25:21] || dif.ex_rd == dif.I1[20:16]);
            exp_rdy = (m_busy == 0) && !haz && (!m_ov || dif.out_ready);
            chk("rnd.in_ready", 64'(dif.in_ready), 64'(exp_rdy));
            chk("rnd.stall", 64'(dif.stall), 64'((haz && dif.in_valid) || m_busy > 0));
            chk("rnd.out_valid", 64'(dif.out_valid), 64'(m_ov));
            if (m_ov) chk_out("rnd", m_exp, m_lbl);
            acc = dif.in_valid && exp_rdy;
            if (m_busy > 0) m_busy--;
            if (acc) begin
                m_ov  = 1'b1;
                m_exp = ref_dec(dif.I1);
                m_lbl = dif.in_label;
                if (m_exp.sys) m_busy = SYSCALL_STALL;
            end else if (dif.out_ready) begin
                m_ov = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
